fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Coefficient writer for the 10-tap FIR pulse filter. It accepts coefficients as a serial valid/ready beat stream from the configuration side and collects them in a shadow bank. It then drives the filter's parallel coefficient inputs from an active bank. The active bank changes only on a complete, well-formed frame, so the filter never sees a partially loaded coefficient set.

## Interface
- NUM_TAPS, 10, number of filter taps (coefficients per frame); legal range ≥ 2
- COEF_W, 16, coefficient width in bits
- clk  in  1  system clock (20 MHz)
- rst_n  in  1  reset, synchronous, active-low
- cfg_valid  in  1  coefficient beat valid
- cfg_data  in  COEF_W  coefficient value, unsigned
- cfg_last  in  1  marks final beat of a frame
- cfg_ready  out  1  loader can accept a beat
- coeff_bus  out  NUM_TAPS*COEF_W  active bank; tap k at bits [k*COEF_W +: COEF_W]
- coeff_update  out  1  one-cycle pulse; active bank was just replaced
- load_err  out  1  one-cycle pulse; frame rejected
- busy  out  1  high whenever state ≠ IDLE

## Operation
- A beat is accepted on a rising edge with cfg_valid && cfg_ready. Beat n (0-based) of a frame writes shadow[n].
- The beat counter idx has width $clog2(NUM_TAPS+1) and resets to 0 at every frame start.
- States:
  - IDLE: cfg_ready=1. On an accepted beat: write shadow[0] and set idx=1. If cfg_last=1, flag a short-frame error and stay in IDLE. Otherwise go to LOAD.
  - LOAD: cfg_ready=1.
    - Accepted beat with idx<NUM_TAPS-1 and cfg_last=1: short-frame error, go to IDLE.
    - Accepted beat with idx==NUM_TAPS-1 and cfg_last=1: go to COMMIT.
    - Accepted beat with idx==NUM_TAPS-1 and cfg_last=0: long-frame error pending, go to DRAIN.
    - Any other accepted beat: idx++.
  - DRAIN: cfg_ready=1. Discard beats until an accepted beat with cfg_last=1, then raise the error and go to IDLE.
  - COMMIT: cfg_ready=0 for exactly one cycle. On the exiting edge, copy shadow to the active bank, assert coeff_update, and go to IDLE.
- On any error, the active bank is untouched. Shadow contents are don't-care.
- cfg_valid=0 mid-frame stalls the frame indefinitely; there is no timeout.
- cfg_data is accepted only when cfg_ready=1; holding cfg_valid during COMMIT has no effect.
- Reset mid-frame: the partial frame is discarded, the active bank returns to reset value, and the state returns to IDLE.

## Timing
- Reset values: coeff_bus all zero, cfg_ready=1, coeff_update=0, load_err=0, busy=0, state IDLE, idx=0.
- cfg_ready and busy are decoded from the registered state. There is no combinational path from cfg_valid.
- Commit latency: if the last beat is accepted at edge N, COMMIT occupies cycle N→N+1. The new coeff_bus and coeff_update=1 appear together after edge N+1, and coeff_update returns to 0 after edge N+2.
- The earliest next-frame beat is accepted at edge N+2.
- load_err goes high after the edge on which the error-terminating beat is accepted and stays high for one cycle.
- All outputs are registered.

## Configuration
- FIR_COEFF_CHECKSUM_EN defined:
  - A frame is NUM_TAPS+1 beats. The final beat carries the COEF_W-bit modulo-2^COEF_W sum of the NUM_TAPS coefficients, and cfg_last is expected on that beat.
  - The length rules apply with NUM_TAPS replaced by NUM_TAPS+1.
  - The running sum resets to 0 at frame start.
  - Checksum match: go to COMMIT. Mismatch: load_err pulse, go to IDLE, no commit.
- FIR_COEFF_CHECKSUM_EN undefined: a frame is exactly NUM_TAPS beats, with no checksum logic.

## Test plan
- Reset check: assert rst_n=0 for 2 cycles, then release → coeff_bus=0, cfg_ready=1, busy=0, coeff_update=0, load_err=0.
- Back-to-back frame: stream values 1..10 with cfg_last on the 10th beat → tap k = k+1, a single coeff_update pulse 2 cycles after the last beat, and cfg_ready=0 for exactly one cycle. With the macro enabled, add an 11th beat of 55 and expect the same result.
- Gapped frame: values 10..1 with cfg_valid low on alternate cycles → tap k = 10-k, one coeff_update pulse, no load_err.
- Short frame: after loading 1..10, send 4 beats of 0xFFFF with cfg_last on the 4th → one load_err pulse, coeff_bus still 1..10, no coeff_update.
- Long frame plus recovery: send 12 beats with cfg_last on the 12th → load_err after the 12th beat, bank unchanged. A following good frame of 7s then commits all taps = 7.
- Reset mid-load: drop rst_n after beat 5 → coeff_bus=0. A following good frame 1..10 commits correctly. With the macro enabled, a frame 1..10 with checksum 54 → load_err, no commit.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader for the 10-tap FIR pulse filter: beats fill a shadow bank and are copied to the active bank only on a well-formed frame.
// Define FIR_COEFF_CHECKSUM_EN to append a modulo-2^COEF_W checksum beat to every frame.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 10,
  parameter int COEF_W   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cfg_valid_i,
  input  logic [COEF_W-1:0]            cfg_data_i,
  input  logic                         cfg_last_i,
  output logic                         cfg_ready_o,
  output logic [NUM_TAPS*COEF_W-1:0]   coeff_bus_o,
  output logic                         coeff_update_o,
  output logic                         load_err_o,
  output logic                         busy_o
);

`ifdef FIR_COEFF_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_TAPS + 1;
`else
  localparam int FRAME_LEN = NUM_TAPS;
`endif
  localparam int                 IDX_W    = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]   TAPS_IDX = IDX_W'(NUM_TAPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         ready_q, busy_q, upd_q, err_q;
  logic [NUM_TAPS*COEF_W-1:0]   bank_q;
  logic [COEF_W-1:0]            shadow_q [NUM_TAPS];
  logic [NUM_TAPS*COEF_W-1:0]   shadow_flat_s;
  logic                         accept_s, err_s, shadow_we_s, csum_ok_s;
  logic [IDX_W-1:0]             wr_idx_s;

  assign accept_s    = cfg_valid_i && ready_q;
  assign shadow_we_s = accept_s && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_LOAD) && (idx_q < TAPS_IDX)));
  assign wr_idx_s    = (state_q == ST_IDLE) ? '0 : idx_q;

`ifdef FIR_COEFF_CHECKSUM_EN
  logic [COEF_W-1:0] sum_q, sum_d;

  // Running sum of the coefficient beats; the checksum beat itself is excluded.
  always_comb begin
    sum_d = sum_q;
    if (accept_s && (state_q == ST_IDLE)) begin
      sum_d = cfg_data_i;
    end else if (shadow_we_s) begin
      sum_d = sum_q + cfg_data_i;
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign csum_ok_s = (cfg_data_i == sum_q);
`else
  assign csum_ok_s = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (accept_s && cfg_last_i) begin
          err_s = 1'b1;
        end else if (accept_s) begin
          state_d = ST_LOAD;
          idx_d   = IDX_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && (idx_q == LAST_IDX)) begin
          idx_d = '0;
          if (!cfg_last_i) begin
            state_d = ST_DRAIN;
          end else if (csum_ok_s) begin
            state_d = ST_COMMIT;
          end else begin
            err_s   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (accept_s && cfg_last_i) begin
          err_s   = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (accept_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DRAIN: begin
        if (accept_s && cfg_last_i) begin
          err_s   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    shadow_flat_s = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      shadow_flat_s[k*COEF_W +: COEF_W] = shadow_q[k];
    end
  end

  // Shadow contents are don't-care after reset or an aborted frame, so no reset here.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (shadow_we_s && (wr_idx_s == IDX_W'(k))) begin
        shadow_q[k] <= cfg_data_i;
      end
    end
  end

  // Handshake/status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= (state_d != ST_COMMIT);
      busy_q  <= (state_d != ST_IDLE);
      upd_q   <= (state_q == ST_COMMIT);
      err_q   <= err_s;
      if (state_q == ST_COMMIT) begin
        bank_q <= shadow_flat_s;
      end
    end
  end

  assign cfg_ready_o    = ready_q;
  assign busy_o         = busy_q;
  assign coeff_update_o = upd_q;
  assign load_err_o     = err_q;
  assign coeff_bus_o    = bank_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: frame-level reference model plus literal checks on directed frames.
module tb_fir_coeff_loader;
  localparam int NUM_TAPS = 10;
  localparam int COEF_W   = 16;
  localparam int BUS_W    = NUM_TAPS * COEF_W;
`ifdef FIR_COEFF_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_TAPS + 1;
`else
  localparam int FRAME_LEN = NUM_TAPS;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [COEF_W-1:0] cfg_data = '0;
  logic              cfg_last = 1'b0;
  logic              cfg_ready, coeff_update, load_err, busy;
  logic [BUS_W-1:0]  coeff_bus;

  int pass_cnt = 0;
  int total_cnt = 0;
  int upd_seen = 0;
  int err_seen = 0;
  bit cmp_en = 1'b0;

  fir_coeff_loader #(.NUM_TAPS(NUM_TAPS), .COEF_W(COEF_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data),
    .cfg_last_i(cfg_last), .cfg_ready_o(cfg_ready), .coeff_bus_o(coeff_bus),
    .coeff_update_o(coeff_update), .load_err_o(load_err), .busy_o(busy)
  );

  always #25 clk = ~clk;

  task automatic chk(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: collects accepted beats per frame and judges each frame on cfg_last.
  logic [COEF_W-1:0] frame_q[$];
  logic [BUS_W-1:0]  exp_bus = '0, pend_bus = '0;
  logic              exp_upd = 1'b0, exp_err = 1'b0, exp_ready = 1'b1, exp_busy = 1'b0, pend = 1'b0;

  function automatic bit frame_ok();
    logic [COEF_W-1:0] s;
    if (frame_q.size() != FRAME_LEN) return 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
    s = '0;
    for (int k = 0; k < NUM_TAPS; k++) s = s + frame_q[k];
    return (s == frame_q[NUM_TAPS]);
`else
    s = '0;
    return (s == '0);
`endif
  endfunction

  function automatic logic [BUS_W-1:0] frame_bus();
    logic [BUS_W-1:0] b;
    b = '0;
    for (int k = 0; k < NUM_TAPS; k++) b[k*COEF_W +: COEF_W] = frame_q[k];
    return b;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      frame_q.delete();
      exp_bus <= '0; exp_upd <= 1'b0; exp_err <= 1'b0;
      exp_ready <= 1'b1; exp_busy <= 1'b0; pend <= 1'b0;
    end else begin
      exp_upd <= 1'b0;
      exp_err <= 1'b0;
      if (pend) begin
        exp_bus <= pend_bus; exp_upd <= 1'b1; pend <= 1'b0;
        exp_ready <= 1'b1; exp_busy <= 1'b0;
      end else if (cfg_valid) begin
        frame_q.push_back(cfg_data);
        if (cfg_last) begin
          if (frame_ok()) begin
            pend <= 1'b1; pend_bus <= frame_bus(); exp_ready <= 1'b0; exp_busy <= 1'b1;
          end else begin
            exp_err <= 1'b1; exp_busy <= 1'b0;
          end
          frame_q.delete();
        end else begin
          exp_busy <= 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("bus", coeff_bus, exp_bus);
      chk("update", BUS_W'(coeff_update), BUS_W'(exp_upd));
      chk("load_err", BUS_W'(load_err), BUS_W'(exp_err));
      chk("ready", BUS_W'(cfg_ready), BUS_W'(exp_ready));
      chk("busy", BUS_W'(busy), BUS_W'(exp_busy));
      if (coeff_update) upd_seen++;
      if (load_err) err_seen++;
    end
  end

  logic [COEF_W-1:0] vals[$];

  function automatic logic [BUS_W-1:0] lin_bus(input int a, input int s);
    logic [BUS_W-1:0] b;
    b = '0;
    for (int k = 0; k < NUM_TAPS; k++) b[k*COEF_W +: COEF_W] = COEF_W'(a + s * k);
    return b;
  endfunction

  task automatic lin_vals(input int a, input int s);
    vals.delete();
    for (int k = 0; k < NUM_TAPS; k++) vals.push_back(COEF_W'(a + s * k));
`ifdef FIR_COEFF_CHECKSUM_EN
    begin
      logic [COEF_W-1:0] cs;
      cs = '0;
      for (int k = 0; k < NUM_TAPS; k++) cs = cs + vals[k];
      vals.push_back(cs);
    end
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the model says the loader is ready (bounded).
  task automatic beat(input logic [COEF_W-1:0] d, input logic l);
    bit ok;
    cfg_valid = 1'b1; cfg_data = d; cfg_last = l;
    for (int t = 0; t < 4; t++) begin
      ok = exp_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic send_vals(input int gap);
    for (int i = 0; i < vals.size(); i++) begin
      beat(vals[i], (i == vals.size() - 1));
      if (gap > 0 && i != vals.size() - 1) idle(gap);
    end
  endtask

  initial begin
    idle(2);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_bus", coeff_bus, '0);
    chk("rst_ready", BUS_W'(cfg_ready), BUS_W'(1));
    chk("rst_busy", BUS_W'(busy), BUS_W'(0));
    chk("rst_update", BUS_W'(coeff_update), BUS_W'(0));
    chk("rst_err", BUS_W'(load_err), BUS_W'(0));

    // Frame 1..10 with precise commit timing.
    lin_vals(1, 1);
`ifdef FIR_COEFF_CHECKSUM_EN
    chk("csum_55", BUS_W'(vals[NUM_TAPS]), BUS_W'(55));
`endif
    send_vals(0);
    chk("commit_ready_low", BUS_W'(cfg_ready), BUS_W'(0));
    chk("commit_upd_early", BUS_W'(coeff_update), BUS_W'(0));
    idle(1);
    chk("commit_upd", BUS_W'(coeff_update), BUS_W'(1));
    chk("commit_ready_back", BUS_W'(cfg_ready), BUS_W'(1));
    chk("bus_1_10", coeff_bus, lin_bus(1, 1));
    idle(1);
    chk("upd_drop", BUS_W'(coeff_update), BUS_W'(0));

    // Frame of 3s immediately followed by a gapped 10..1 frame held through COMMIT.
    lin_vals(3, 0);
    send_vals(0);
    lin_vals(10, -1);
    send_vals(1);
    idle(3);
    chk("bus_10_1", coeff_bus, lin_bus(10, -1));
    chk("upd_cnt_a", BUS_W'(upd_seen), BUS_W'(3));
    chk("err_cnt_a", BUS_W'(err_seen), BUS_W'(0));

    // Short frame keeps the bank.
    lin_vals(1, 1);
    send_vals(0);
    idle(2);
    for (int i = 0; i < 4; i++) beat(16'hFFFF, (i == 3));
    idle(2);
    chk("short_bus", coeff_bus, lin_bus(1, 1));
    chk("short_err", BUS_W'(err_seen), BUS_W'(1));
    chk("short_upd", BUS_W'(upd_seen), BUS_W'(4));

    // Long frame, then recovery with 7s.
    for (int i = 0; i < 12; i++) beat(COEF_W'(100 + i), (i == 11));
    idle(2);
    chk("long_bus", coeff_bus, lin_bus(1, 1));
    chk("long_err", BUS_W'(err_seen), BUS_W'(2));
    lin_vals(7, 0);
    send_vals(0);
    idle(3);
    chk("bus_7s", coeff_bus, lin_bus(7, 0));

    // Reset mid-load.
    for (int i = 0; i < 5; i++) beat(COEF_W'(i + 1), 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("midrst_bus", coeff_bus, '0);
    chk("midrst_busy", BUS_W'(busy), BUS_W'(0));
    lin_vals(1, 1);
    send_vals(0);
    idle(3);
    chk("post_rst_bus", coeff_bus, lin_bus(1, 1));
`ifdef FIR_COEFF_CHECKSUM_EN
    vals[NUM_TAPS] = COEF_W'(54);
    send_vals(0);
    idle(3);
    chk("bad_csum_bus", coeff_bus, lin_bus(1, 1));
    chk("bad_csum_err", BUS_W'(err_seen), BUS_W'(3));
`endif
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
